// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debouncer family: state encoding,
// state width and the counter-width helper.
package debounce_pkg;

  localparam int unsigned ST_W = 3;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t DEB_P  = 3'd1;
  localparam state_t PRESS  = 3'd2;
  localparam state_t HOLD   = 3'd3;
  localparam state_t REPEAT = 3'd4;
  localparam state_t DEB_R  = 3'd5;

  // Bits needed to count up to the largest of the three periods (minimum 1).
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// Single debouncer channel: polarity correction, 2-flop synchroniser,
// press/hold/repeat FSM with one shared counter and registered pulse outputs.
// Optional feature: MULTI_DEBOUNCER_REL_EN enables the release pulse.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int unsigned DB_CYC   = 1_000_000,
  parameter int unsigned HOLD_CYC = 25_000_000,
  parameter int unsigned RPT_CYC  = 5_000_000,
  parameter logic        ACT_LOW  = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pb,
  output logic         dpb,
  output logic         scen,
  output logic         mcen,
  output logic         ccen,
  output logic         rel,
  output logic [ST_W-1:0] state
);

  localparam int unsigned CW = cnt_width(DB_CYC, HOLD_CYC, RPT_CYC);
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] RPT_LAST  = CW'(RPT_CYC - 1);

  logic [1:0]    sync_q;
  logic          s;
  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          wrap_c;
  logic          dpb_d;
  logic          scen_d;
  logic          mcen_d;
  logic          ccen_d;
  logic          rel_d;

  // Polarity-correct and synchronise the raw button.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], pb ^ ACT_LOW};
  end

  assign s = sync_q[1];

  // State and counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wrap_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = DEB_P;
          cnt_d   = '0;
        end
      end
      DEB_P: begin
        if (!s)                   state_d = IDLE;
        else if (cnt_q == DB_LAST) state_d = PRESS;
        else                      cnt_d   = cnt_q + CW'(1);
      end
      PRESS: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
      HOLD: begin
        if (!s) begin
          state_d = DEB_R;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = REPEAT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      REPEAT: begin
        if (!s) begin
          state_d = DEB_R;
          cnt_d   = '0;
        end else if (cnt_q == RPT_LAST) begin
          wrap_c = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DEB_R: begin
        // A bounce back to pressed restarts the release filter.
        if (s)                     cnt_d   = '0;
        else if (cnt_q == DB_LAST) state_d = IDLE;
        else                       cnt_d   = cnt_q + CW'(1);
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state, registered below.
  always_comb begin
    dpb_d  = (state_d == PRESS) || (state_d == HOLD) ||
             (state_d == REPEAT) || (state_d == DEB_R);
    scen_d = (state_d == PRESS) && (state_q != PRESS);
    mcen_d = scen_d || wrap_c;
    ccen_d = (state_d == REPEAT);
`ifdef MULTI_DEBOUNCER_REL_EN
    rel_d  = (state_q == DEB_R) && (state_d == IDLE);
`else
    rel_d  = 1'b0;
`endif
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dpb  <= 1'b0;
      scen <= 1'b0;
      mcen <= 1'b0;
      ccen <= 1'b0;
      rel  <= 1'b0;
    end else begin
      dpb  <= dpb_d;
      scen <= scen_d;
      mcen <= mcen_d;
      ccen <= ccen_d;
      rel  <= rel_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/multi_debouncer.sv
// N-channel push-button debouncer: one independent debounce_ch per button,
// all on a single clock. Optional feature: MULTI_DEBOUNCER_REL_EN drives REL;
// without it REL is tied low.
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned     N_CH     = 4,
  parameter int unsigned     DB_CYC   = 1_000_000,
  parameter int unsigned     HOLD_CYC = 25_000_000,
  parameter int unsigned     RPT_CYC  = 5_000_000,
  parameter logic [N_CH-1:0] ACT_LOW  = {N_CH{1'b0}}
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [N_CH-1:0]      PB,
  output logic [N_CH-1:0]      DPB,
  output logic [N_CH-1:0]      SCEN,
  output logic [N_CH-1:0]      MCEN,
  output logic [N_CH-1:0]      CCEN,
  output logic [N_CH-1:0]      REL,
  output logic [ST_W*N_CH-1:0] STATE
);

  // One debouncer per channel.
  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    debounce_ch #(
      .DB_CYC  (DB_CYC),
      .HOLD_CYC(HOLD_CYC),
      .RPT_CYC (RPT_CYC),
      .ACT_LOW (ACT_LOW[i])
    ) u_ch (
      .clk  (CLK),
      .rst_n(RESET),
      .pb   (PB[i]),
      .dpb  (DPB[i]),
      .scen (SCEN[i]),
      .mcen (MCEN[i]),
      .ccen (CCEN[i]),
      .rel  (REL[i]),
      .state(STATE[i*ST_W +: ST_W])
    );
  end

endmodule
